// File: rtl/display_pkg.sv
// Shared constants, state type and BCD helper for the HEX display controller.
// Leading-zero blanking of the score field is enabled by defining HEX_BLANK_EN.
package display_pkg;

  localparam int NUM_REQ = 3;
  localparam int SCORE = 0;
  localparam int LIVES = 1;
  localparam int LEVEL = 2;

  localparam int SCORE_MAX = 9999;
  localparam int DIGIT_MAX = 9;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } disp_state_t;

  function automatic logic [15:0] add3(
    input logic [15:0] a
  );
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ?
        a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 4-digit BCD converter, one bit per cycle.
// done flags the edge that performs the final shift.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] bin_in,
  output logic [15:0]  bcd,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [15:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [15:0]   acc_adj;

  assign acc_adj = add3(acc_q);
  assign done    = run_q && (cnt_q == CW'(W - 1));
  assign bcd     = acc_q;

  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      sr_d  = bin_in;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = {acc_adj[14:0], sr_q[W-1]};
      sr_d  = {sr_q[W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/seg7.sv
// Hex digit to active-low 7-segment decoder, bit order gfedcba.
// Code 4'hF is reserved as blank.
module seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'h7F;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Round-robin arbitrated BCD update controller for six HEX displays.
// Define HEX_BLANK_EN for leading-zero blanking of the score digits.
module hex_display_ctrl
  import display_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         req,
  input  logic [SCORE_W-1:0] score_val,
  input  logic [3:0]         lives_val,
  input  logic [3:0]         level_val,
  output logic [2:0]         ack,
  output logic               busy,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
);

  disp_state_t       state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [5:0][3:0]   dig_q, dig_d;
  logic [1:0]        pick;
  logic              start;
  logic              done;
  logic [15:0]       bcd;
  logic [SCORE_W-1:0] load_val;
  logic [SCORE_W-1:0] sat_score;
  logic [3:0]        sat_lives;
  logic [3:0]        sat_level;
  logic [3:0][3:0]   score_nib;

  // Search starts just after the last grant, so it ends up lowest.
  always_comb begin
    int idx;
    logic found;
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = 2'(idx);
      end
    end
  end

  assign sat_score = (32'(score_val) > 32'(SCORE_MAX)) ?
    SCORE_W'(SCORE_MAX) : score_val;
  assign sat_lives = (lives_val > 4'(DIGIT_MAX)) ?
    4'(DIGIT_MAX) : lives_val;
  assign sat_level = (level_val > 4'(DIGIT_MAX)) ?
    4'(DIGIT_MAX) : level_val;

  always_comb begin
    load_val = sat_score;
    unique case (pick)
      2'(LIVES): load_val = SCORE_W'(sat_lives);
      2'(LEVEL): load_val = SCORE_W'(sat_level);
      default:   load_val = sat_score;
    endcase
  end

  always_comb begin
    score_nib = bcd;
`ifdef HEX_BLANK_EN
    if (bcd[15:12] == 4'h0) score_nib[3] = BLANK_CODE;
    if (bcd[15:8] == 8'h00) score_nib[2] = BLANK_CODE;
    if (bcd[15:4] == 12'h000) score_nib[1] = BLANK_CODE;
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    dig_d   = dig_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = CONV;
          grant_d = pick;
          last_d  = pick;
          start   = 1'b1;
        end
      end
      CONV: begin
        if (done) state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
        unique case (grant_q)
          2'(SCORE): dig_d[3:0] = score_nib;
          2'(LIVES): dig_d[4]   = bcd[3:0];
          2'(LEVEL): dig_d[5]   = bcd[3:0];
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 2'(SCORE);
      last_q  <= 2'(LEVEL);
      dig_q   <= {6{BLANK_CODE}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dig_q   <= dig_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign ack  = (state_q == WRITE) ? (3'b001 << grant_q) : 3'b000;

  bin2bcd_seq #(.W(SCORE_W)) u_b2b (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (load_val),
    .bcd     (bcd),
    .done    (done)
  );

  seg7 u_seg0 (.digit(dig_q[0]), .seg(HEX0));
  seg7 u_seg1 (.digit(dig_q[1]), .seg(HEX1));
  seg7 u_seg2 (.digit(dig_q[2]), .seg(HEX2));
  seg7 u_seg3 (.digit(dig_q[3]), .seg(HEX3));
  seg7 u_seg4 (.digit(dig_q[4]), .seg(HEX4));
  seg7 u_seg5 (.digit(dig_q[5]), .seg(HEX5));

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized self-checking bench for hex_display_ctrl.
// Reference model works on decimal digits and a round-robin pointer.
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [13:0] score_val = '0;
  logic [3:0]  lives_val = '0;
  logic [3:0]  level_val = '0;
  logic [2:0]  ack;
  logic        busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0]  hex [6];

  int n_cmp = 0;
  int n_err = 0;
  int last_g = 2;
  int exp_d [6];

  hex_display_ctrl #(.SCORE_W(14)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .score_val (score_val),
    .lives_val (lives_val),
    .level_val (level_val),
    .ack       (ack),
    .busy      (busy),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5)
  );

  always #5 clk = ~clk;

  assign hex[0] = HEX0;
  assign hex[1] = HEX1;
  assign hex[2] = HEX2;
  assign hex[3] = HEX3;
  assign hex[4] = HEX4;
  assign hex[5] = HEX5;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int seg_exp(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int pick_rr(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last_g + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_hex(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_hex%0d", tag, i), int'(hex[i]), seg_exp(exp_d[i]));
  endtask

  task automatic model_reset();
    last_g = 2;
    for (int i = 0; i < 6; i++) exp_d[i] = -1;
  endtask

  task automatic model_write(input int win, input int v);
    if (win == 0) begin
      exp_d[0] = v % 10;
      exp_d[1] = (v / 10) % 10;
      exp_d[2] = (v / 100) % 10;
      exp_d[3] = v / 1000;
`ifdef HEX_BLANK_EN
      if (v < 1000) exp_d[3] = -1;
      if (v < 100)  exp_d[2] = -1;
      if (v < 10)   exp_d[1] = -1;
`endif
    end else begin
      exp_d[win + 3] = v;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    check_hex("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Caller is just after an edge in IDLE with req nonzero.
  task automatic do_round(input bit keep, input logic [2:0] raise,
                          input bit viol);
    int win, v;
    win = pick_rr(req);
    if (win == 0) v = (int'(score_val) > 9999) ? 9999 : int'(score_val);
    else if (win == 1) v = (int'(lives_val) > 9) ? 9 : int'(lives_val);
    else v = (int'(level_val) > 9) ? 9 : int'(level_val);
    last_g = win;
    @(posedge clk);
    #1;
    chk("grant_busy", int'(busy), 1);
    chk("grant_ack", int'(ack), 0);
    score_val = 14'($urandom);
    lives_val = 4'($urandom);
    level_val = 4'($urandom);
    req = req | raise;
    if (viol) req[win] = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("ack_early", int'(ack), 0);
    @(posedge clk);
    #1;
    chk("ack", int'(ack), 1 << win);
    chk("ack_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    chk("post_ack", int'(ack), 0);
    chk("post_busy", int'(busy), 0);
    model_write(win, v);
    check_hex("upd");
    if (!keep) req[win] = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    score_val = 14'd1234;
    req = 3'b001;
    do_round(1'b0, 3'b000, 1'b0);
    chk("s1234_hex3", int'(HEX3), 7'b1111001);
    chk("s1234_hex0", int'(HEX0), 7'b0011001);
    chk("s1234_hex4", int'(HEX4), 7'h7F);

    score_val = 14'd12000;
    lives_val = 4'd13;
    req = 3'b011;
    do_round(1'b0, 3'b000, 1'b0);
    score_val = 14'd12000;
    do_round(1'b0, 3'b000, 1'b0);
    chk("sat_hex3", int'(HEX3), 7'b0010000);
    chk("sat_hex4", int'(HEX4), 7'b0010000);

    score_val = 14'd7;
    req = 3'b001;
    do_round(1'b0, 3'b000, 1'b0);
    chk("blank_hex0", int'(HEX0), 7'b1111000);
`ifdef HEX_BLANK_EN
    chk("blank_hex1", int'(HEX1), 7'h7F);
`else
    chk("blank_hex1", int'(HEX1), 7'b1000000);
`endif

    req = 3'b111;
    do_reset();
    do_round(1'b0, 3'b000, 1'b0);
    chk("rr_first", last_g, 0);
    do_round(1'b0, 3'b000, 1'b0);
    do_round(1'b0, 3'b001, 1'b0);
    chk("rr_third", last_g, 2);
    do_round(1'b0, 3'b000, 1'b0);
    chk("rr_rearm", last_g, 0);

    lives_val = 4'd3;
    req = 3'b010;
    do_round(1'b0, 3'b000, 1'b0);
    score_val = 14'd4321;
    req = 3'b001;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    req = 3'b000;
    #1;
    model_reset();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ack", int'(ack), 0);
    check_hex("mid_rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk("no_ack", int'(ack), 0);
    end
    score_val = 14'd4321;
    req = 3'b001;
    do_round(1'b0, 3'b000, 1'b0);

    for (int r = 0; r < 40; r++) begin
      if (req == 3'b000) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1 chk("idle_busy", int'(busy), 0);
        end
        req = 3'($urandom_range(1, 7));
      end
      score_val = 14'($urandom);
      lives_val = 4'($urandom);
      level_val = 4'($urandom);
      do_round($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
